// File: rtl/servo_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// servo_cmd_scheduler
//
// Purpose:
//   Buffers 10-bit servo instructions from the serial instruction receiver in
//   a small FIFO and decodes them one at a time. Holds per-channel position,
//   target, slew rate and enable. On every PWM frame tick it sweeps the
//   channels in order and moves each enabled channel's position one slew step
//   toward its target.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-low reset
//   instr_valid  in   instr_data holds an instruction
//   instr_ready  out  FIFO has room (not full)
//   instr_data   in   [9:8] opcode, [7:6] channel, [5:0] argument
//   frame_tick   in   one-cycle pulse at each PWM frame start
//   pos_out      out  channel c position at [c*POS_W +: POS_W]
//   en_out       out  per-channel enable
//   busy         out  FSM active, FIFO non-empty or tick pending
//   frame_done   out  one-cycle pulse after the last channel of a sweep
//   tick_overrun out  sticky flag: a frame tick arrived while one was pending
// -----------------------------------------------------------------------------
module servo_cmd_scheduler #(
   parameter int         NUM_CH       = 4,
   parameter int         POS_W        = 6,
   parameter int         FIFO_DEPTH   = 4,
   parameter logic [3:0] DEFAULT_RATE = 4'd1,
   parameter int         MID_POS      = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      instr_valid,
   output logic                      instr_ready,
   input  logic [9:0]                instr_data,
   input  logic                      frame_tick,
   output logic [NUM_CH*POS_W-1:0]   pos_out,
   output logic [NUM_CH-1:0]         en_out,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      tick_overrun
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [1:0] OP_SET_POS  = 2'b00;
   localparam logic [1:0] OP_SET_RATE = 2'b01;
   localparam logic [1:0] OP_ENABLE   = 2'b10;
   localparam logic [1:0] OP_STOP_ALL = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXEC   = 2'd1,
      UPDATE = 2'd2
   } state_t;

   // ---------------------------------------------------------------- FIFO
   logic [9:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;

   assign fifo_full   = (count_reg == CNT_W'(FIFO_DEPTH));
   assign fifo_empty  = (count_reg == '0);
   assign instr_ready = !fifo_full;
   assign push        = instr_valid && !fifo_full;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= instr_data;
      end
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Head of queue, decoded during EXEC.
   logic [9:0] head;
   logic [1:0] head_op;
   logic [1:0] head_ch;
   logic [5:0] head_arg;

   assign head     = fifo_mem[rd_ptr_reg];
   assign head_op  = head[9:8];
   assign head_ch  = head[7:6];
   assign head_arg = head[5:0];

   // ---------------------------------------------------------------- FSM
   state_t           state_reg, state_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic             tick_pending_reg;
   logic             frame_done_reg;
   logic             tick_overrun_reg;
   logic             sweep_end;

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      pop        = 1'b0;
      sweep_end  = 1'b0;
      case (state_reg)
         IDLE: begin
            // A pending frame tick is serviced before queued instructions.
            if (tick_pending_reg) begin
               state_next = UPDATE;
               idx_next   = '0;
            end else if (!fifo_empty) begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            pop        = 1'b1;
            state_next = IDLE;
         end
         UPDATE: begin
            if (idx_reg == IDX_W'(NUM_CH - 1)) begin
               sweep_end  = 1'b1;
               idx_next   = '0;
               state_next = IDLE;
            end else begin
               idx_next = idx_reg + IDX_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg        <= IDLE;
         idx_reg          <= '0;
         tick_pending_reg <= 1'b0;
         frame_done_reg   <= 1'b0;
         tick_overrun_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         idx_reg        <= idx_next;
         frame_done_reg <= sweep_end;
         // A new tick wins over the end-of-sweep clear so it is not lost;
         // extra ticks are merged into the single pending flag.
         if (frame_tick) begin
            tick_pending_reg <= 1'b1;
         end else if (sweep_end) begin
            tick_pending_reg <= 1'b0;
         end
         if (frame_tick && (tick_pending_reg || state_reg == UPDATE)) begin
            tick_overrun_reg <= 1'b1;
         end
      end
   end

   assign busy         = (state_reg != IDLE) || !fifo_empty || tick_pending_reg;
   assign frame_done   = frame_done_reg;
   assign tick_overrun = tick_overrun_reg;

   // ---------------------------------------------------------------- channels
   logic exec_now;
   logic stop_all;

   assign exec_now = (state_reg == EXEC);
   assign stop_all = exec_now && (head_op == OP_STOP_ALL);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [POS_W-1:0] cur_reg;
         logic [POS_W-1:0] target_reg;
         logic [3:0]       rate_reg;
         logic             en_reg;
         logic             sel;
         logic             step_en;
         logic [POS_W:0]   up_sum;
         logic [POS_W:0]   down_sum;
         logic [POS_W-1:0] step_pos;

         // Instructions addressed to a channel number >= NUM_CH match no
         // channel here, so they are simply popped and discarded.
         assign sel     = exec_now && (head_op != OP_STOP_ALL) && (head_ch == 2'(gi));
         assign step_en = (state_reg == UPDATE) && (idx_reg == IDX_W'(gi)) && en_reg;

         // One extra bit: the sum cannot wrap and a borrow shows up in the MSB.
         assign up_sum   = {1'b0, cur_reg} + (POS_W+1)'(rate_reg);
         assign down_sum = {1'b0, cur_reg} - (POS_W+1)'(rate_reg);

         always_comb begin
            step_pos = cur_reg;
            if (cur_reg < target_reg) begin
               if (up_sum >= {1'b0, target_reg}) begin
                  step_pos = target_reg;
               end else begin
                  step_pos = up_sum[POS_W-1:0];
               end
            end else if (cur_reg > target_reg) begin
               if (down_sum[POS_W] || (down_sum <= {1'b0, target_reg})) begin
                  step_pos = target_reg;
               end else begin
                  step_pos = down_sum[POS_W-1:0];
               end
            end
         end

         always_ff @(posedge clk) begin
            if (!reset) begin
               cur_reg    <= POS_W'(MID_POS);
               target_reg <= POS_W'(MID_POS);
               rate_reg   <= DEFAULT_RATE;
               en_reg     <= 1'b0;
            end else begin
               if (stop_all) begin
                  en_reg     <= 1'b0;
                  target_reg <= cur_reg;
               end else if (sel) begin
                  case (head_op)
                     OP_SET_POS:  target_reg <= POS_W'(head_arg);
                     OP_SET_RATE: rate_reg   <= head_arg[3:0];
                     OP_ENABLE:   en_reg     <= head_arg[0];
                     default:     ;
                  endcase
               end
               // EXEC and UPDATE never overlap, so no conflict with the above.
               if (step_en) begin
                  cur_reg <= step_pos;
               end
            end
         end

         assign pos_out[gi*POS_W +: POS_W] = cur_reg;
         assign en_out[gi]                 = en_reg;
      end
   endgenerate

endmodule

// File: tb/tb_servo_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_servo_cmd_scheduler
//
// Purpose:
//   Directed self-checking bench for servo_cmd_scheduler (default parameters).
//   A table of {instruction, frame ticks, expected positions/enables} records
//   is applied in a loop, followed by hand-written sequences for latency,
//   FIFO backpressure, STOP_ALL, tick overrun and reset during a sweep.
// -----------------------------------------------------------------------------
module tb_servo_cmd_scheduler;

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [9:0]  instr_data;
   logic        frame_tick;
   logic [23:0] pos_out;
   logic [3:0]  en_out;
   logic        busy;
   logic        frame_done;
   logic        tick_overrun;

   int n_vec = 0;
   int n_bad = 0;

   servo_cmd_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_data   (instr_data),
      .frame_tick   (frame_tick),
      .pos_out      (pos_out),
      .en_out       (en_out),
      .busy         (busy),
      .frame_done   (frame_done),
      .tick_overrun (tick_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic        do_instr;
      logic [9:0]  instr;
      int          ticks;
      logic [23:0] exp_pos;
      logic [3:0]  exp_en;
   } vec_t;

   vec_t vecs [13];

   function automatic logic [23:0] pk(input int c0, input int c1, input int c2, input int c3);
      return {6'(c3), 6'(c2), 6'(c1), 6'(c0)};
   endfunction

   function automatic logic [9:0] ins(input logic [1:0] op, input logic [1:0] ch, input logic [5:0] arg);
      return {op, ch, arg};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [9:0] d);
      int n = 0;
      while (!instr_ready && n < 50) begin
         step();
         n++;
      end
      chk("send_ready", instr_ready, 1);
      instr_valid = 1'b1;
      instr_data  = d;
      step();
      instr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         step();
         n++;
      end
      chk("idle", busy, 0);
   endtask

   task automatic tick();
      int n = 0;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      while (!frame_done && n < 20) begin
         step();
         n++;
      end
      chk("frame_done", frame_done, 1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   logic [9:0] bseq [6];
   int         k;
   int         cyc;
   int         dones;
   logic       rdy;
   logic       seen_full;

   initial begin
      reset       = 1'b0;
      instr_valid = 1'b0;
      instr_data  = '0;
      frame_tick  = 1'b0;

      // Position walk on ch1, slew-down with clamp on ch2, enable/disable cases.
      vecs[0]  = '{1'b1, ins(2'b00, 2'd1, 6'd40),  0, pk(32, 32, 32, 32), 4'b0000};
      vecs[1]  = '{1'b1, ins(2'b10, 2'd1, 6'd1),   1, pk(32, 33, 32, 32), 4'b0010};
      vecs[2]  = '{1'b0, 10'd0,                    7, pk(32, 40, 32, 32), 4'b0010};
      vecs[3]  = '{1'b0, 10'd0,                    1, pk(32, 40, 32, 32), 4'b0010};
      vecs[4]  = '{1'b1, ins(2'b01, 2'd2, 6'h35),  0, pk(32, 40, 32, 32), 4'b0010};
      vecs[5]  = '{1'b1, ins(2'b00, 2'd2, 6'd0),   0, pk(32, 40, 32, 32), 4'b0010};
      vecs[6]  = '{1'b1, ins(2'b10, 2'd2, 6'd1),   1, pk(32, 40, 27, 32), 4'b0110};
      vecs[7]  = '{1'b0, 10'd0,                    5, pk(32, 40, 2, 32),  4'b0110};
      vecs[8]  = '{1'b0, 10'd0,                    1, pk(32, 40, 0, 32),  4'b0110};
      vecs[9]  = '{1'b0, 10'd0,                    1, pk(32, 40, 0, 32),  4'b0110};
      vecs[10] = '{1'b1, ins(2'b10, 2'd3, 6'h3e),  1, pk(32, 40, 0, 32),  4'b0110};
      vecs[11] = '{1'b1, ins(2'b10, 2'd1, 6'd0),   0, pk(32, 40, 0, 32),  4'b0100};
      vecs[12] = '{1'b1, ins(2'b00, 2'd1, 6'd10),  2, pk(32, 40, 0, 32),  4'b0100};

      // Reset state
      step();
      step();
      reset = 1'b1;
      chk("rst_pos", pos_out, pk(32, 32, 32, 32));
      chk("rst_en", en_out, 0);
      chk("rst_ready", instr_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", tick_overrun, 0);
      chk("rst_done", frame_done, 0);
      $display("reset: pos=%h en=%b ready=%b busy=%b", pos_out, en_out, instr_ready, busy);

      // Table-driven vectors
      for (int i = 0; i < 13; i++) begin
         if (vecs[i].do_instr) begin
            send(vecs[i].instr);
         end
         wait_idle();
         for (int t = 0; t < vecs[i].ticks; t++) begin
            tick();
            wait_idle();
         end
         chk($sformatf("vec%0d_pos", i), pos_out, vecs[i].exp_pos);
         chk($sformatf("vec%0d_en", i), en_out, vecs[i].exp_en);
         $display("vec %0d: instr=%h ticks=%0d pos=%h en=%b", i, vecs[i].instr, vecs[i].ticks, pos_out, en_out);
      end

      // Instruction latency: accepted at edge N, visible at edge N+2
      do_reset();
      instr_valid = 1'b1;
      instr_data  = ins(2'b10, 2'd3, 6'd1);
      step();
      instr_valid = 1'b0;
      chk("lat_n0_en", en_out, 0);
      chk("lat_n0_busy", busy, 1);
      step();
      chk("lat_n1_en", en_out, 0);
      step();
      chk("lat_n2_en", en_out, 4'b1000);
      $display("latency: en after N+2 = %b", en_out);

      // Tick latency: channel 3 updates on tick-edge + 5
      send(ins(2'b00, 2'd3, 6'd40));
      wait_idle();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      step();
      step();
      step();
      chk("tlat_t4_ch3", pos_out[23:18], 32);
      chk("tlat_t4_done", frame_done, 0);
      step();
      chk("tlat_t5_ch3", pos_out[23:18], 33);
      chk("tlat_t5_done", frame_done, 1);
      $display("tick latency: ch3=%0d done=%b", pos_out[23:18], frame_done);

      // FIFO fill during a sweep: 6 back-to-back instructions
      do_reset();
      bseq[0] = ins(2'b00, 2'd0, 6'd10);
      bseq[1] = ins(2'b00, 2'd0, 6'd20);
      bseq[2] = ins(2'b01, 2'd0, 6'd3);
      bseq[3] = ins(2'b00, 2'd1, 6'd5);
      bseq[4] = ins(2'b00, 2'd0, 6'd50);
      bseq[5] = ins(2'b10, 2'd0, 6'd1);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      k = 0;
      cyc = 0;
      seen_full = 1'b0;
      while (k < 6 && cyc < 60) begin
         instr_valid = 1'b1;
         instr_data  = bseq[k];
         rdy = instr_ready;
         step();
         cyc++;
         if (rdy) k++;
         if (k == 4 && !seen_full) begin
            seen_full = 1'b1;
            chk("fifo_full_ready", instr_ready, 0);
         end
      end
      instr_valid = 1'b0;
      chk("fifo_all_accepted", k, 6);
      wait_idle();
      chk("fifo_en", en_out, 4'b0001);
      chk("fifo_pos_before", pos_out, pk(32, 32, 32, 32));
      tick();
      wait_idle();
      chk("fifo_pos_after", pos_out, pk(35, 32, 32, 32));
      $display("fifo order: pos=%h en=%b", pos_out, en_out);

      // STOP_ALL mid-motion
      tick();
      wait_idle();
      chk("stop_pre_pos", pos_out, pk(38, 32, 32, 32));
      send(ins(2'b11, 2'd2, 6'h2a));
      wait_idle();
      chk("stop_en", en_out, 0);
      tick();
      wait_idle();
      chk("stop_frozen", pos_out, pk(38, 32, 32, 32));
      send(ins(2'b10, 2'd0, 6'd1));
      wait_idle();
      tick();
      wait_idle();
      chk("stop_reenable_en", en_out, 4'b0001);
      chk("stop_reenable_pos", pos_out, pk(38, 32, 32, 32));
      $display("stop_all: pos=%h en=%b", pos_out, en_out);

      // Two ticks two cycles apart: merged into one sweep, overrun flagged
      send(ins(2'b00, 2'd0, 6'd50));
      wait_idle();
      chk("ovr_before", tick_overrun, 0);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("ovr_flag", tick_overrun, 1);
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         if (frame_done) dones++;
         step();
      end
      chk("ovr_sweeps", dones, 1);
      chk("ovr_pos", pos_out, pk(41, 32, 32, 32));
      chk("ovr_sticky", tick_overrun, 1);
      $display("overrun: sweeps=%0d pos=%h ovr=%b", dones, pos_out, tick_overrun);

      // Reset in the middle of a sweep
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      reset = 1'b0;
      step();
      chk("mid_rst_pos", pos_out, pk(32, 32, 32, 32));
      chk("mid_rst_en", en_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ovr", tick_overrun, 0);
      chk("mid_rst_done", frame_done, 0);
      chk("mid_rst_ready", instr_ready, 1);
      reset = 1'b1;
      step();
      $display("mid-sweep reset: pos=%h en=%b busy=%b", pos_out, en_out, busy);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
